instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 26 ++
 rtl/instr_encoder.sv | 80 ++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request, clear and instruction-word handshake bundle for instr_encoder.
interface instr_encoder_if;
   logic        clear;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  format;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [31:0] imm;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] instr;
   logic [9:0]  wr_addr;
   logic        error;
   modport master (
      output clear, req_valid, format, rd, rs1, rs2, funct3, funct7b5, imm, word_ready,
      input  req_ready, word_valid, instr, wr_addr, error
   );
   modport slave (
      input  clear, req_valid, format, rd, rs1, rs2, funct3, funct7b5, imm, word_ready,
      output req_ready, word_valid, instr, wr_addr, error
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns one request into one RV32I word (two for the LI pseudo) with sequential write addresses.
module instr_encoder (
   input logic           clk,
   input logic           rst_n,
   instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SEND, SEND_LUI, SEND_ADDI} state_t;
   state_t      state, next;
   logic [2:0]  fmt, f3;
   logic [4:0]  rd, rs1, rs2;
   logic        f7;
   logic [31:0] imm;
   logic [31:0] enc;
   logic [19:0] hi;
   logic        take, accept, bad;
   assign take           = bus.req_valid && bus.req_ready;
   assign bad            = bus.format == 3'd2 && bus.imm[0];
   assign accept         = bus.word_valid && bus.word_ready;
   assign bus.req_ready  = state == IDLE;
   assign bus.word_valid = state != IDLE;
   assign bus.instr      = bus.word_valid ? enc : '0;
   always_comb begin
      next = state;
      case (state)
         IDLE:     if (take) next = bus.format == 3'd7 ? SEND_LUI : bad ? IDLE : SEND;
         SEND:     if (accept) next = IDLE;
         SEND_LUI: if (accept) next = SEND_ADDI;
         default:  if (accept) next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fmt <= '0;
         f3  <= '0;
         rd  <= '0;
         rs1 <= '0;
         rs2 <= '0;
         f7  <= 1'b0;
         imm <= '0;
      end else if (take) begin
         fmt <= bus.format;
         f3  <= bus.funct3;
         rd  <= bus.rd;
         rs1 <= bus.rs1;
         rs2 <= bus.rs2;
         f7  <= bus.funct7b5;
         imm <= bus.imm;
      end
   // Clear wins over an acceptance for the address, but never hides a same-cycle error
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.wr_addr <= '0;
         bus.error   <= 1'b0;
      end else begin
         bus.wr_addr <= bus.clear ? '0 : accept ? bus.wr_addr + 10'd1 : bus.wr_addr;
         bus.error   <= (bus.error && !bus.clear) || (take && bad);
      end
   // The lui upper field is pre-incremented so the sign-extended addi low part lands exactly
   assign hi = imm[31:12] + 20'(imm[11]);
   always_comb begin
      enc = '0;
      if (state == SEND_LUI) enc = {hi, rd, 7'b0110111};
      else if (state == SEND_ADDI) enc = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
      else
         case (fmt)
            3'd0:    enc = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            3'd1:    enc = (f3 == 3'b001 || f3 == 3'b101) ?
                           {1'b0, f7, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011} :
                           {imm[11:0], rs1, f3, rd, 7'b0010011};
            3'd2:    enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            3'd3:    enc = {imm[11:0], rs1, f3, rd, 7'b0000011};
            3'd4:    enc = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            3'd5:    enc = {imm[31:12], rd, 7'b0010111};
            default: enc = {imm[31:12], rd, 7'b0110111};
         endcase
   end
endmodule
